// File: rtl/axi_arb2_pkg.sv
// Shared types and AXI constants for the two-requester AXI front end.
package axi_arb_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WR,
        ST_B
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B        = 3'd3;
endpackage

// File: rtl/axi_arb2_if.sv
// Single-beat AXI4 bus between the arbiter (master) and the memory model (slave).
interface axi_arb2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  arvalid, arready;
    logic [ADDR_W-1:0]     araddr;
    logic [3:0]            arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid, rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  awvalid, awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [3:0]            awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid, wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  bvalid, bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  arready, rvalid, rdata, rresp, rlast,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output arready, rvalid, rdata, rresp, rlast,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_arb2_rr.sv
// Two-way round-robin picker; bit 0 = IFU, bit 1 = LSU. The pointer starts at
// "IFU last" so the LSU wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);
    logic last_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                last_q <= 1'b0;
        else if (upd_i && |gnt_o)  last_q <= gnt_o[1];
    end

    assign last_o = last_q;
endmodule

// File: rtl/axi_arb2.sv
// Shares one AXI4 slave port between IFU reads and LSU reads/writes,
// one single-beat transaction at a time, round-robin granted.
module axi_arb2 import axi_arb_pkg::*; #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 64,
    parameter logic [3:0] IF_ID  = 4'd0,
    parameter logic [3:0] LS_ID  = 4'd1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                ls_req,
    input  logic                ls_wen,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_ack,
    output logic                ls_done,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,
    axi_arb2_if.master          axi
);
    localparam int STRB_W = DATA_W / 8;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          id_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                aw_ok_q, w_ok_q;
    logic                if_ack_q, ls_ack_q, if_done_q, ls_done_q, if_err_q, ls_err_q;
    logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;

    logic [1:0] gnt;
    logic       owner_ls;
    logic       aw_hs, w_hs, rerr;

    // The arbiter pointer is updated at grant, so it also names the current owner.
    rr_arb2 u_rr (
        .clk    (aclk),
        .rst_n  (aresetn),
        .req_i  ({ls_req, if_req}),
        .upd_i  (state_q == ST_IDLE),
        .gnt_o  (gnt),
        .last_o (owner_ls)
    );

    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q & axi.wready;
    assign rerr  = (axi.rresp != AXI_RESP_OKAY) || !axi.rlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            id_q       <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            ls_err_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            ls_ack_q  <= 1'b0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            if_err_q  <= 1'b0;
            ls_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt[1]) begin
                        addr_q   <= ls_addr;
                        wdata_q  <= ls_wdata;
                        wstrb_q  <= ls_wstrb;
                        id_q     <= LS_ID;
                        ls_ack_q <= 1'b1;
                        if (ls_wen) begin
                            state_q   <= ST_WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_ok_q   <= 1'b0;
                            w_ok_q    <= 1'b0;
                        end else begin
                            state_q   <= ST_AR;
                            arvalid_q <= 1'b1;
                        end
                    end else if (gnt[0]) begin
                        addr_q    <= if_addr;
                        id_q      <= IF_ID;
                        if_ack_q  <= 1'b1;
                        state_q   <= ST_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                ST_AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (owner_ls) begin
                            ls_rdata_q <= axi.rdata;
                            ls_done_q  <= 1'b1;
                            ls_err_q   <= rerr;
                        end else begin
                            if_rdata_q <= axi.rdata;
                            if_done_q  <= 1'b1;
                            if_err_q   <= rerr;
                        end
                    end
                end
                ST_WR: begin
                    // AW and W complete independently; B follows once both are in.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_ok_q   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_ok_q   <= 1'b1;
                    end
                    if ((aw_ok_q || aw_hs) && (w_ok_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi.bvalid) begin
                        bready_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                        ls_err_q  <= (axi.bresp != AXI_RESP_OKAY);
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arid    = id_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = SIZE_8B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.rready  = rready_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awid    = LS_ID;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = SIZE_8B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wvalid_q;
    assign axi.bready  = bready_q;

    assign if_ack   = if_ack_q;
    assign if_done  = if_done_q;
    assign if_rdata = if_rdata_q;
    assign if_err   = if_err_q;
    assign ls_ack   = ls_ack_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;
    assign ls_err   = ls_err_q;
endmodule

// File: tb/tb_axi_arb2.sv
// Directed bench for axi_arb2 with a small reactive SRAM slave that has a
// one-cycle read latency after accepting AR.
module tb_axi_arb2;
    localparam int AW = 32;
    localparam int DW = 64;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            if_req, if_ack, if_done, if_err;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            ls_req, ls_wen, ls_ack, ls_done, ls_err;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata, ls_rdata;
    logic [DW/8-1:0] ls_wstrb;

    axi_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_arb2 #(.ADDR_W(AW), .DATA_W(DW), .IF_ID(4'd0), .LS_ID(4'd1)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .ls_req   (ls_req),
        .ls_wen   (ls_wen),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_wstrb (ls_wstrb),
        .ls_ack   (ls_ack),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .ls_err   (ls_err),
        .axi      (bus)
    );

    always #5 aclk = ~aclk;

    int nvec = 0;
    int nerr = 0;
    int dn;

    // slave configuration, set by the directed sequence
    int            ar_wait = 0, aw_wait = 0, w_wait = 0;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp, b_resp;
    logic          r_last;

    int ar_cnt, aw_cnt, w_cnt, r_stage;
    bit aw_hs, w_hs;

    always @(negedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
            bus.rresp = 2'b00; bus.rlast = 1'b0;
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_stage = 0; aw_hs = 0; w_hs = 0;
        end else begin
            case (r_stage)
                1: r_stage = 2;
                2: begin
                    bus.rvalid = 1'b1; bus.rdata = r_data;
                    bus.rresp = r_resp; bus.rlast = r_last;
                    if (bus.rready) r_stage = 3;
                end
                3: begin bus.rvalid = 1'b0; r_stage = 0; end
                default: ;
            endcase
            if (bus.arvalid && r_stage == 0) begin
                bus.arready = (ar_cnt == ar_wait);
                if (bus.arready) r_stage = 1;
                ar_cnt++;
            end else begin
                bus.arready = 1'b0; ar_cnt = 0;
            end
            if (bus.awvalid && !aw_hs) begin
                bus.awready = (aw_cnt == aw_wait);
                if (bus.awready) aw_hs = 1;
                aw_cnt++;
            end else begin
                bus.awready = 1'b0; aw_cnt = 0;
            end
            if (bus.wvalid && !w_hs) begin
                bus.wready = (w_cnt == w_wait);
                if (bus.wready) w_hs = 1;
                w_cnt++;
            end else begin
                bus.wready = 1'b0; w_cnt = 0;
            end
            if (bus.bvalid) begin
                bus.bvalid = 1'b0; aw_hs = 0; w_hs = 0;
            end else if (aw_hs && w_hs && bus.bready) begin
                bus.bvalid = 1'b1; bus.bresp = b_resp;
            end
        end
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit lsu, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge aclk);
            seen = lsu ? ls_done : if_done;
        end
        chk(tag, {159'd0, seen}, 160'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        r_data = '0; r_resp = 2'b00; r_last = 1'b1; b_resp = 2'b00;
        repeat (2) @(negedge aclk);
        chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'b0);
        chk("rst_pulses", {if_ack, ls_ack, if_done, ls_done, if_err, ls_err}, 6'b0);
        chk("rst_data", {bus.araddr, bus.awaddr, bus.wdata, bus.wstrb}, '0);
        aresetn = 1'b1;
        @(negedge aclk);

        // both requesting out of reset: LSU, then IFU, then LSU
        if_req = 1'b1; if_addr = 32'h8000_0100;
        ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_0200;
        r_data = 64'h0101_0202_0303_0404;
        @(negedge aclk);
        chk("tie1_ack", {ls_ack, if_ack}, 2'b10);
        chk("tie1_ar", {bus.arvalid, bus.arid, bus.araddr}, {1'b1, 4'd1, 32'h8000_0200});
        ls_req = 1'b0;
        wait_done(1'b1, "tie1_done");
        chk("tie1_rdata", ls_rdata, 64'h0101_0202_0303_0404);
        ls_req = 1'b1; ls_addr = 32'h8000_0300;
        @(negedge aclk);
        chk("tie2_ack", {ls_ack, if_ack}, 2'b01);
        chk("tie2_ar", {bus.arid, bus.araddr}, {4'd0, 32'h8000_0100});
        if_req = 1'b0;
        @(negedge aclk);
        chk("tie2_ack_width", {ls_ack, if_ack}, 2'b00);
        wait_done(1'b0, "tie2_done");
        @(negedge aclk);
        chk("tie3_ack", {ls_ack, if_ack}, 2'b10);
        chk("tie3_ar", {bus.arid, bus.araddr}, {4'd1, 32'h8000_0300});
        ls_req = 1'b0;
        wait_done(1'b1, "tie3_done");
        @(negedge aclk);

        // IFU read alone, zero-wait slave: ack at cycle 1, done at cycle 4
        if_req = 1'b1; if_addr = 32'h8000_0000; r_data = 64'h1122_3344_5566_7788;
        @(negedge aclk);
        chk("rd_c1", {if_ack, bus.arvalid, bus.arid, bus.araddr}, {1'b1, 1'b1, 4'd0, 32'h8000_0000});
        chk("rd_ar_const", {bus.arlen, bus.arsize, bus.arburst}, {8'd0, 3'd3, 2'b01});
        if_req = 1'b0;
        @(negedge aclk);
        chk("rd_c2", {if_ack, if_done, bus.arvalid, bus.rready}, 4'b0001);
        @(negedge aclk);
        chk("rd_c3", if_done, 1'b0);
        @(negedge aclk);
        chk("rd_c4", {if_done, if_err, if_rdata}, {1'b1, 1'b0, 64'h1122_3344_5566_7788});
        @(negedge aclk);
        chk("rd_c5", if_done, 1'b0);

        // LSU write, AW accepted one cycle before W
        aw_wait = 0; w_wait = 1;
        ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 32'h8000_0010;
        ls_wdata = 64'hDEAD_BEEF_CAFE_F00D; ls_wstrb = 8'h0F;
        @(negedge aclk);
        chk("wr_c1", {ls_ack, bus.awvalid, bus.wvalid, bus.wlast, bus.awid, bus.awaddr},
            {4'b1111, 4'd1, 32'h8000_0010});
        chk("wr_c1_w", {bus.wdata, bus.wstrb}, {64'hDEAD_BEEF_CAFE_F00D, 8'h0F});
        chk("wr_aw_const", {bus.awlen, bus.awsize, bus.awburst}, {8'd0, 3'd3, 2'b01});
        ls_req = 1'b0; ls_wen = 1'b0;
        @(negedge aclk);
        chk("wr_c2", {bus.awvalid, bus.wvalid, bus.wlast, bus.bready}, 4'b0110);
        @(negedge aclk);
        chk("wr_c3", {bus.wvalid, bus.wlast, bus.bready, ls_done}, 4'b0010);
        @(negedge aclk);
        chk("wr_c4", {ls_done, ls_err, bus.bready}, 3'b100);
        w_wait = 0;
        @(negedge aclk);

        // AR stalled five cycles: payload held
        ar_wait = 5;
        if_req = 1'b1; if_addr = 32'h8000_0040; r_data = 64'hA5A5_5A5A_0F0F_F0F0;
        @(negedge aclk);
        if_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("ar_hold", {bus.arvalid, bus.arid, bus.araddr}, {1'b1, 4'd0, 32'h8000_0040});
            @(negedge aclk);
        end
        chk("ar_drop", bus.arvalid, 1'b0);
        wait_done(1'b0, "stall_done");
        chk("stall_rdata", if_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
        ar_wait = 0;

        // SLVERR on an LSU read
        r_resp = 2'b10; r_data = 64'h0000_0000_0000_00EE;
        ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_0020;
        @(negedge aclk);
        ls_req = 1'b0;
        wait_done(1'b1, "slverr_done");
        chk("slverr_err", {ls_err, ls_rdata}, {1'b1, 64'h0000_0000_0000_00EE});
        r_resp = 2'b00;

        // missing rlast flags an error
        r_last = 1'b0;
        if_req = 1'b1; if_addr = 32'h8000_0050;
        @(negedge aclk);
        if_req = 1'b0;
        wait_done(1'b0, "rlast_done");
        chk("rlast_err", if_err, 1'b1);
        r_last = 1'b1;
        @(negedge aclk);

        // reset while in R: outputs clear at once, no done
        if_req = 1'b1; if_addr = 32'h8000_0080;
        @(negedge aclk);
        if_req = 1'b0;
        @(negedge aclk);
        chk("pre_rst_rready", bus.rready, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst", {bus.rready, bus.arvalid, if_ack, if_done, if_err, bus.araddr}, '0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            dn += int'(if_done);
        end
        chk("no_done_after_rst", dn, 0);
        if_req = 1'b1; if_addr = 32'h8000_0090; r_data = 64'h1357_9BDF_2468_ACE0;
        @(negedge aclk);
        chk("post_rst_ack", {if_ack, bus.araddr}, {1'b1, 32'h8000_0090});
        if_req = 1'b0;
        wait_done(1'b0, "post_rst_done");
        chk("post_rst_rdata", {if_err, if_rdata}, {1'b0, 64'h1357_9BDF_2468_ACE0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
